mmio_rr_arbiter: RTL

Two-master round-robin arbiter that shares one peripheral `mmio_if` register port (SPI or UART) between the CPU MMIO path and a second requester such as the DMA/debug engine. It sits between the address-decode interconnect and a single peripheral. It keeps exactly one transaction outstanding at the slave. It captures the slave's next-cycle read data into a response buffer and returns a valid/ready response to the owning master for both reads and writes.

---
 rtl/mmio_rr_arbiter_if.sv | 34 +++
 rtl/mmio_rr_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mmio_rr_arbiter_if.sv
// Bundle for the two-master request/response side and the single peripheral register port.
// The arbiter is a slave to the masters and a master to the peripheral.
interface mmio_rr_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic [1:0]          m_req_valid;
  logic [1:0]          m_req_ready;
  logic [1:0]          m_req_we;
  logic [2*ADDR_W-1:0] m_req_addr;
  logic [63:0]         m_req_wdata;
  logic [7:0]          m_req_wstrb;
  logic [1:0]          m_resp_valid;
  logic [1:0]          m_resp_ready;
  logic [31:0]         m_resp_rdata;
  logic                m_resp_we;

  logic                s_valid;
  logic                s_we;
  logic [ADDR_W-1:0]   s_addr;
  logic [31:0]         s_wdata;
  logic [3:0]          s_wstrb;
  logic                s_ready;
  logic [31:0]         s_rdata;

  modport slave (
    input  m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_wstrb, m_resp_ready,
    output m_req_ready, m_resp_valid, m_resp_rdata, m_resp_we
  );

  modport master (
    output s_valid, s_we, s_addr, s_wdata, s_wstrb,
    input  s_ready, s_rdata
  );
endinterface

// File: rtl/mmio_rr_arbiter.sv
// Two-master round-robin arbiter sharing one peripheral register port, one transaction
// outstanding, with a buffered valid/ready response back to the owning master.
module mmio_rr_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mmio_rr_arbiter_if.slave      req_bus,
  mmio_rr_arbiter_if.master     periph_bus
);

  typedef enum logic [1:0] {IDLE, CAPTURE, RESP} state_t;

  state_t      state_reg, state_next;
  logic        rr_reg;
  logic        locked_reg;
  logic        lock_id_reg;
  logic        owner_reg;
  logic        own_we_reg;
  logic [31:0] rdata_reg;

  logic [ADDR_W-1:0] req_addr  [2];
  logic [31:0]       req_wdata [2];
  logic [3:0]        req_wstrb [2];

  logic        winner;
  logic        win_valid;
  logic        accept;

  logic              s_valid_c;
  logic              s_we_c;
  logic [ADDR_W-1:0] s_addr_c;
  logic [31:0]       s_wdata_c;
  logic [3:0]        s_wstrb_c;
  logic [1:0]        m_req_ready_c;
  logic [1:0]        m_resp_valid_c;
  logic [31:0]       m_resp_rdata_c;
  logic              m_resp_we_c;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign req_addr[gi]  = req_bus.m_req_addr[gi*ADDR_W +: ADDR_W];
      assign req_wdata[gi] = req_bus.m_req_wdata[gi*32 +: 32];
      assign req_wstrb[gi] = req_bus.m_req_wstrb[gi*4 +: 4];
    end
  endgenerate

  // A presented-but-stalled request keeps its grant; otherwise rr names the preferred master.
  always_comb begin
    winner = rr_reg;
    if (locked_reg)
      winner = lock_id_reg;
    else if (!req_bus.m_req_valid[rr_reg] && req_bus.m_req_valid[~rr_reg])
      winner = ~rr_reg;
  end

  assign win_valid = req_bus.m_req_valid[winner];
  assign accept    = (state_reg == IDLE) && win_valid && periph_bus.s_ready;

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (req_bus.m_resp_ready[owner_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_reg      <= 1'b0;
      locked_reg  <= 1'b0;
      lock_id_reg <= 1'b0;
      owner_reg   <= 1'b0;
      own_we_reg  <= 1'b0;
      rdata_reg   <= 32'd0;
    end else begin
      if (state_reg == IDLE) begin
        if (accept) begin
          owner_reg  <= winner;
          own_we_reg <= req_bus.m_req_we[winner];
          rr_reg     <= ~winner;
          locked_reg <= 1'b0;
        end else if (win_valid) begin
          locked_reg  <= 1'b1;
          lock_id_reg <= winner;
        end else begin
          // Also releases a lock whose holder withdrew its request.
          locked_reg <= 1'b0;
        end
      end
      if (state_reg == CAPTURE)
        rdata_reg <= own_we_reg ? 32'd0 : periph_bus.s_rdata;
    end
  end

  always_comb begin
    s_valid_c      = 1'b0;
    s_we_c         = 1'b0;
    s_addr_c       = '0;
    s_wdata_c      = 32'd0;
    s_wstrb_c      = 4'd0;
    m_req_ready_c  = 2'b00;
    m_resp_valid_c = 2'b00;
    m_resp_rdata_c = 32'd0;
    m_resp_we_c    = 1'b0;
    case (state_reg)
      IDLE: begin
        s_valid_c             = win_valid;
        s_we_c                = req_bus.m_req_we[winner];
        s_addr_c              = req_addr[winner];
        s_wdata_c             = req_wdata[winner];
        s_wstrb_c             = req_wstrb[winner];
        m_req_ready_c[winner] = win_valid & periph_bus.s_ready;
      end
      RESP: begin
        m_resp_valid_c[owner_reg] = 1'b1;
        m_resp_rdata_c            = rdata_reg;
        m_resp_we_c               = own_we_reg;
      end
      default: ;
    endcase
  end

  assign periph_bus.s_valid   = s_valid_c;
  assign periph_bus.s_we      = s_we_c;
  assign periph_bus.s_addr    = s_addr_c;
  assign periph_bus.s_wdata   = s_wdata_c;
  assign periph_bus.s_wstrb   = s_wstrb_c;
  assign req_bus.m_req_ready  = m_req_ready_c;
  assign req_bus.m_resp_valid = m_resp_valid_c;
  assign req_bus.m_resp_rdata = m_resp_rdata_c;
  assign req_bus.m_resp_we    = m_resp_we_c;

endmodule
